// File: rtl/updown_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and its surroundings (bounds, controls,
// counter load/enable/direction and counter feedback).
interface updown_sweep_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
);
    logic               start;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [SWEEP_W-1:0] sweeps;
    logic               pause;
    logic               abort;
    logic [WIDTH-1:0]   count_in;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_load_val;
    logic               cnt_en;
    logic               cnt_up_down;
    logic               busy;
    logic               done;
    logic               err;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
        output start, lo, hi, sweeps, pause, abort, count_in,
        input  cnt_load, cnt_load_val, cnt_en, cnt_up_down, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, lo, hi, sweeps, pause, abort, count_in,
        output cnt_load, cnt_load_val, cnt_en, cnt_up_down, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: load lo, sweep lo->hi->lo
// a latched number of times, with pause/abort, then pulse done.
//
// state | meaning
// IDLE  | waiting for start; rejected starts pulse err next cycle
// LOAD  | load counter with latched lo
// UP    | counting up until the counter reaches hi
// DOWN  | counting down until the counter reaches lo; closes a sweep
// DONE  | one-cycle completion pulse
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    updown_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [SWEEP_W-1:0] ONE_S = SWEEP_W'(1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [SWEEP_W-1:0] sweeps_q, sweep_cnt_q;
    logic               err_q;
    logic               start_ok, start_bad, sweep_inc;
    logic               cnt_load, cnt_en, cnt_up_down, done;

    always_comb begin
        start_ok    = bus.start && (bus.lo < bus.hi) && (bus.sweeps != '0);
        start_bad   = bus.start && !start_ok;
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_up_down = 1'b0;
        done        = 1'b0;
        sweep_inc   = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = LOAD;
            LOAD: begin
                if (bus.abort) state_nxt = IDLE;
                else begin
                    cnt_load  = 1'b1;
                    state_nxt = UP;
                end
            end
            UP: begin
                if (bus.abort) state_nxt = IDLE;
                else if (!bus.pause) begin
                    cnt_en      = 1'b1;
                    cnt_up_down = 1'b1;
                    // Turn on the edge that brings the counter to hi: no dwell at the top.
                    if (bus.count_in >= hi_q - ONE_W) state_nxt = DOWN;
                end
            end
            DOWN: begin
                if (bus.abort) state_nxt = IDLE;
                else if (!bus.pause) begin
                    cnt_en = 1'b1;
                    if (bus.count_in <= lo_q + ONE_W) begin
                        sweep_inc = 1'b1;
                        state_nxt = (sweep_cnt_q + ONE_S == sweeps_q) ? DONE : UP;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done      = !bus.abort;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && start_bad;
            if ((state == IDLE) && start_ok) begin
                lo_q        <= bus.lo;
                hi_q        <= bus.hi;
                sweeps_q    <= bus.sweeps;
                sweep_cnt_q <= '0;
            end else if (sweep_inc) begin
                sweep_cnt_q <= sweep_cnt_q + ONE_S;
            end
        end
    end

    assign bus.cnt_load     = cnt_load;
    assign bus.cnt_load_val = lo_q;
    assign bus.cnt_en       = cnt_en;
    assign bus.cnt_up_down  = cnt_up_down;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done;
    assign bus.err          = err_q;
    assign bus.sweep_cnt    = sweep_cnt_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural up/down counter in the loop.
module tb_updown_sweep_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] cnt = 4'd0;
    int tests = 0;
    int fails = 0;

    updown_sweep_ctrl_if #(.WIDTH(4), .SWEEP_W(4)) bus ();
    updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cnt_load)    cnt <= bus.cnt_load_val;
        else if (bus.cnt_en) cnt <= bus.cnt_up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign bus.count_in = cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " busy"}, 32'(bus.busy), 0);
        check({tag, " done"}, 32'(bus.done), 0);
        check({tag, " err"}, 32'(bus.err), 0);
        check({tag, " load"}, 32'(bus.cnt_load), 0);
        check({tag, " en"}, 32'(bus.cnt_en), 0);
        check({tag, " dir"}, 32'(bus.cnt_up_down), 0);
    endtask

    task automatic do_start(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s);
        bus.lo = l; bus.hi = h; bus.sweeps = s; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int exp1[13] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    int exp4[7]  = '{3, 4, 3, 4, 3, 4, 3};
    int exp5[5]  = '{1, 2, 3, 2, 1};

    initial begin
        bus.start = 0; bus.lo = 0; bus.hi = 0; bus.sweeps = 0; bus.pause = 0; bus.abort = 0;
        tick(); tick();
        idle_outputs("reset");
        check("reset sweep_cnt", 32'(bus.sweep_cnt), 0);
        check("reset load_val", 32'(bus.cnt_load_val), 0);
        reset = 1'b1;
        tick();

        // 1: basic two-sweep run, with an ignored start mid-run
        do_start(4'd2, 4'd5, 4'd2);
        check("t1 load", 32'(bus.cnt_load), 1);
        check("t1 load_val", 32'(bus.cnt_load_val), 2);
        check("t1 busy", 32'(bus.busy), 1);
        for (int k = 0; k < 13; k++) begin
            if (k == 4) begin bus.lo = 4'd0; bus.hi = 4'd9; bus.start = 1'b1; end
            tick();
            bus.start = 1'b0;
            check($sformatf("t1 count[%0d]", k), 32'(cnt), 32'(exp1[k]));
            check($sformatf("t1 done[%0d]", k), 32'(bus.done), (k == 12) ? 1 : 0);
            check($sformatf("t1 load[%0d]", k), 32'(bus.cnt_load), 0);
        end
        check("t1 sweep_cnt", 32'(bus.sweep_cnt), 2);
        check("t1 load_val kept", 32'(bus.cnt_load_val), 2);
        tick();
        check("t1 busy after", 32'(bus.busy), 0);
        check("t1 done after", 32'(bus.done), 0);
        check("t1 count hold", 32'(cnt), 2);
        check("t1 sweep_cnt hold", 32'(bus.sweep_cnt), 2);

        // 2: rejected starts
        do_start(4'd7, 4'd7, 4'd1);
        check("t2a err", 32'(bus.err), 1);
        check("t2a busy", 32'(bus.busy), 0);
        check("t2a load", 32'(bus.cnt_load), 0);
        tick();
        check("t2a err clr", 32'(bus.err), 0);
        check("t2a load2", 32'(bus.cnt_load), 0);
        do_start(4'd1, 4'd4, 4'd0);
        check("t2b err", 32'(bus.err), 1);
        check("t2b busy", 32'(bus.busy), 0);
        check("t2b load", 32'(bus.cnt_load), 0);
        tick();
        check("t2b err clr", 32'(bus.err), 0);
        check("t2b busy2", 32'(bus.busy), 0);

        // 3: full-range sweep with a 3-cycle pause at 9
        do_start(4'd0, 4'd15, 4'd1);
        check("t3 sweep_cnt clr", 32'(bus.sweep_cnt), 0);
        tick();
        check("t3 count0", 32'(cnt), 0);
        for (int v = 1; v <= 9; v++) begin
            tick();
            check($sformatf("t3 up %0d", v), 32'(cnt), 32'(v));
        end
        bus.pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            check($sformatf("t3 pause count %0d", p), 32'(cnt), 9);
            check($sformatf("t3 pause en %0d", p), 32'(bus.cnt_en), 0);
            check($sformatf("t3 pause busy %0d", p), 32'(bus.busy), 1);
        end
        bus.pause = 1'b0;
        for (int v = 10; v <= 15; v++) begin
            tick();
            check($sformatf("t3 up %0d", v), 32'(cnt), 32'(v));
        end
        for (int v = 14; v >= 0; v--) begin
            tick();
            check($sformatf("t3 down %0d", v), 32'(cnt), 32'(v));
            check($sformatf("t3 done %0d", v), 32'(bus.done), (v == 0) ? 1 : 0);
        end
        check("t3 sweep_cnt", 32'(bus.sweep_cnt), 1);
        tick();
        check("t3 busy after", 32'(bus.busy), 0);

        // 4: minimum range, three sweeps
        do_start(4'd3, 4'd4, 4'd3);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t4 count[%0d]", k), 32'(cnt), 32'(exp4[k]));
            check($sformatf("t4 done[%0d]", k), 32'(bus.done), (k == 6) ? 1 : 0);
        end
        check("t4 sweep_cnt", 32'(bus.sweep_cnt), 3);
        tick();
        check("t4 busy after", 32'(bus.busy), 0);

        // 5: abort in DOWN at 6, then a fresh run
        do_start(4'd1, 4'd8, 4'd1);
        for (int k = 0; k < 10; k++) tick();
        check("t5 count pre-abort", 32'(cnt), 6);
        check("t5 dir down", 32'(bus.cnt_up_down), 0);
        check("t5 en down", 32'(bus.cnt_en), 1);
        bus.abort = 1'b1;
        #1;
        check("t5 abort en", 32'(bus.cnt_en), 0);
        check("t5 abort load", 32'(bus.cnt_load), 0);
        tick();
        idle_outputs("t5 post-abort");
        check("t5 count held", 32'(cnt), 6);
        bus.abort = 1'b0;
        tick();
        check("t5 count still", 32'(cnt), 6);
        check("t5 no done", 32'(bus.done), 0);
        do_start(4'd1, 4'd3, 4'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t5 rerun[%0d]", k), 32'(cnt), 32'(exp5[k]));
            check($sformatf("t5 rerun done[%0d]", k), 32'(bus.done), (k == 4) ? 1 : 0);
        end
        tick();

        // 6: ignored start while busy, then reset mid-UP with pause and abort high
        do_start(4'd2, 4'd9, 4'd1);
        tick(); tick();
        check("t6 count", 32'(cnt), 3);
        bus.lo = 4'd5; bus.hi = 4'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t6 no relatch", 32'(bus.cnt_load_val), 2);
        check("t6 no reload", 32'(cnt), 4);
        check("t6 still up", 32'(bus.cnt_up_down), 1);
        bus.pause = 1'b1; bus.abort = 1'b1; reset = 1'b0;
        tick();
        idle_outputs("t6 reset");
        check("t6 reset sweep_cnt", 32'(bus.sweep_cnt), 0);
        check("t6 reset load_val", 32'(bus.cnt_load_val), 0);
        bus.pause = 1'b0; bus.abort = 1'b0; reset = 1'b1;
        tick();
        check("t6 idle busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
